// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM states, IRQ count, vector layout.
// The controller's synchronizer depth is chosen by macro INT_CTRL_SYNC_EN (see interrupt_controller.sv).
package pa_microcode;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACKED   = 2'd2
  } irq_state_t;

  localparam int IRQ_COUNT = 8;
  localparam int IDX_W     = 3;
  localparam int BASE_W    = 4;

  // int_vector = {base, idx, 1'b0}
  localparam int VEC_BASE_LSB = 4;
  localparam int VEC_IDX_LSB  = 1;

  function automatic logic [7:0] make_vector(input logic [BASE_W-1:0] base,
                                             input logic [IDX_W-1:0]  idx);
    logic [7:0] v;
    v = '0;
    v[VEC_BASE_LSB +: BASE_W] = base;
    v[VEC_IDX_LSB  +: IDX_W]  = idx;
    return v;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Bus between the CPU sequencer/register file (master) and the interrupt controller (slave).
interface interrupt_controller_if;
  import pa_microcode::*;

  logic [IRQ_COUNT-1:0] irq_in;
  logic [7:0]           z_bus;
  logic                 ctrl_irq_masks_wrt;
  logic                 ctrl_int_vector_wrt;
  logic                 ctrl_int_ack;
  logic                 ctrl_clear_all_ints;
  logic                 irq_en;
  logic                 int_pending;
  logic [7:0]           int_vector;
  logic [IRQ_COUNT-1:0] irq_masks;
  logic [IRQ_COUNT-1:0] irq_status;

  modport master (
    output irq_in, z_bus, ctrl_irq_masks_wrt, ctrl_int_vector_wrt,
           ctrl_int_ack, ctrl_clear_all_ints, irq_en,
    input  int_pending, int_vector, irq_masks, irq_status
  );

  modport slave (
    input  irq_in, z_bus, ctrl_irq_masks_wrt, ctrl_int_vector_wrt,
           ctrl_int_ack, ctrl_clear_all_ints, irq_en,
    output int_pending, int_vector, irq_masks, irq_status
  );
endinterface

// File: rtl/interrupt_controller_priority.sv
// Combinational fixed-priority encoder: returns the lowest set request index (bit 0 wins).
module irq_priority_encoder
  import pa_microcode::*;
(
  input  logic [IRQ_COUNT-1:0] req,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  logic [IRQ_COUNT-1:0] grant;

  assign grant[0] = req[0];

  generate
    for (genvar gi = 1; gi < IRQ_COUNT; gi++) begin : g_grant
      assign grant[gi] = req[gi] & ~(|req[gi-1:0]);
    end
  endgenerate

  // grant is one-hot (or zero), so OR-ing the indices yields the winner
  always_comb begin
    idx = '0;
    for (int i = 0; i < IRQ_COUNT; i++) begin
      if (grant[i]) idx = idx | IDX_W'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/interrupt_controller.sv
// Vectored interrupt controller: edge-latched pending bits, mask/base registers, ack FSM.
// Define INT_CTRL_SYNC_EN for a two-flop synchronizer per irq_in line (default: one stage).
module interrupt_controller
  import pa_microcode::*;
(
  input  logic                  clk,
  input  logic                  arst,
  interrupt_controller_if.slave bus
);

  logic [IRQ_COUNT-1:0] sync_reg;
  logic [IRQ_COUNT-1:0] hist_reg;
  logic [IRQ_COUNT-1:0] edge_det;
  logic [IRQ_COUNT-1:0] pending_reg, pending_next;
  logic [IRQ_COUNT-1:0] mask_reg;
  logic [BASE_W-1:0]    base_reg;
  logic [IRQ_COUNT-1:0] ack_clr;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_valid;
  logic                 qualified;
  logic                 accept;
  irq_state_t           state_reg;
  logic                 int_pending_reg;
  logic [7:0]           int_vector_reg;

`ifdef INT_CTRL_SYNC_EN
  logic [IRQ_COUNT-1:0] meta_reg;

  always_ff @(posedge clk) begin
    if (arst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= bus.irq_in;
      sync_reg <= meta_reg;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (arst) sync_reg <= '0;
    else      sync_reg <= bus.irq_in;
  end
`endif

  // History resets to 0 so a line already high at reset release counts as one edge
  always_ff @(posedge clk) begin
    if (arst) hist_reg <= '0;
    else      hist_reg <= sync_reg;
  end

  assign edge_det = sync_reg & ~hist_reg;

  irq_priority_encoder u_prio (
    .req   (pending_reg & mask_reg),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  assign qualified = bus.irq_en & sel_valid;
  assign accept    = (state_reg == PENDING) & qualified & bus.ctrl_int_ack;
  assign ack_clr   = accept ? (IRQ_COUNT'(1) << sel_idx) : '0;

  // clear_all beats a new edge; a new edge beats the ack-clear of its own bit
  generate
    for (genvar gi = 0; gi < IRQ_COUNT; gi++) begin : g_pending
      assign pending_next[gi] = ~bus.ctrl_clear_all_ints &
                                (edge_det[gi] | (pending_reg[gi] & ~ack_clr[gi]));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (arst) begin
      pending_reg <= '0;
      mask_reg    <= '0;
      base_reg    <= '0;
    end else begin
      pending_reg <= pending_next;
      if (bus.ctrl_irq_masks_wrt)  mask_reg <= bus.z_bus;
      if (bus.ctrl_int_vector_wrt) base_reg <= bus.z_bus[7:4];
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_reg       <= IDLE;
      int_pending_reg <= 1'b0;
      int_vector_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (qualified) begin
            state_reg       <= PENDING;
            int_pending_reg <= 1'b1;
          end
        end
        PENDING: begin
          if (!qualified) begin
            state_reg       <= IDLE;
            int_pending_reg <= 1'b0;
          end else if (bus.ctrl_int_ack) begin
            int_vector_reg  <= make_vector(base_reg, sel_idx);
            state_reg       <= ACKED;
            int_pending_reg <= 1'b0;
          end
        end
        ACKED: begin
          state_reg       <= IDLE;
          int_pending_reg <= 1'b0;
        end
        default: begin
          state_reg       <= IDLE;
          int_pending_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.int_pending = int_pending_reg;
  assign bus.int_vector  = int_vector_reg;
  assign bus.irq_masks   = mask_reg;
  assign bus.irq_status  = pending_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller; latencies follow INT_CTRL_SYNC_EN.
module tb_interrupt_controller;

  logic clk;
  logic arst;
  int   n_cmp;
  int   n_err;

`ifdef INT_CTRL_SYNC_EN
  localparam int PEND_EDGE = 3;
`else
  localparam int PEND_EDGE = 2;
`endif

  interrupt_controller_if bus ();

  interrupt_controller dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_masks(input logic [7:0] v);
    bus.z_bus = v;
    bus.ctrl_irq_masks_wrt = 1'b1;
    tick(1);
    bus.ctrl_irq_masks_wrt = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.ctrl_int_ack = 1'b1;
    tick(1);
    bus.ctrl_int_ack = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    tick(2);
    n_cmp++; if (bus.int_pending !== 1'b0) begin n_err++; $display("FAIL reset_int_pending got=%b want=0", bus.int_pending); end
    n_cmp++; if (bus.int_vector !== 8'h00) begin n_err++; $display("FAIL reset_int_vector got=%h want=00", bus.int_vector); end
    n_cmp++; if (bus.irq_masks !== 8'h00) begin n_err++; $display("FAIL reset_masks got=%h want=00", bus.irq_masks); end
    n_cmp++; if (bus.irq_status !== 8'h00) begin n_err++; $display("FAIL reset_status got=%h want=00", bus.irq_status); end
    arst = 1'b0;
    tick(1);
    $display("reset: done");
  endtask

  task automatic test_setup();
    write_masks(8'hFF);
    bus.z_bus = 8'hA0;
    bus.ctrl_int_vector_wrt = 1'b1;
    tick(1);
    bus.ctrl_int_vector_wrt = 1'b0;
    n_cmp++; if (bus.irq_masks !== 8'hFF) begin n_err++; $display("FAIL setup_masks got=%h want=FF", bus.irq_masks); end
    $display("setup: masks=%h base=A", bus.irq_masks);
  endtask

  task automatic test_single();
    bus.irq_en = 1'b1;
    bus.irq_in = 8'h08;
    tick(PEND_EDGE - 1);
    n_cmp++; if (bus.irq_status !== 8'h00) begin n_err++; $display("FAIL single_early_status got=%h want=00", bus.irq_status); end
    tick(1);
    n_cmp++; if (bus.irq_status !== 8'h08) begin n_err++; $display("FAIL single_status got=%h want=08", bus.irq_status); end
    n_cmp++; if (bus.int_pending !== 1'b0) begin n_err++; $display("FAIL single_early_req got=%b want=0", bus.int_pending); end
    tick(1);
    n_cmp++; if (bus.int_pending !== 1'b1) begin n_err++; $display("FAIL single_req got=%b want=1", bus.int_pending); end
    pulse_ack();
    n_cmp++; if (bus.int_vector !== 8'hA6) begin n_err++; $display("FAIL single_vector got=%h want=A6", bus.int_vector); end
    n_cmp++; if (bus.irq_status !== 8'h00) begin n_err++; $display("FAIL single_cleared got=%h want=00", bus.irq_status); end
    n_cmp++; if (bus.int_pending !== 1'b0) begin n_err++; $display("FAIL single_acked_req got=%b want=0", bus.int_pending); end
    tick(1);
    n_cmp++; if (bus.int_pending !== 1'b0) begin n_err++; $display("FAIL single_post_ack_req got=%b want=0", bus.int_pending); end
    tick(4);
    n_cmp++; if (bus.irq_status !== 8'h00) begin n_err++; $display("FAIL single_level_once got=%h want=00", bus.irq_status); end
    $display("single: vector=%h status=%h", bus.int_vector, bus.irq_status);
  endtask

  task automatic test_priority();
    bus.irq_in = 8'h2C;
    tick(PEND_EDGE);
    n_cmp++; if (bus.irq_status !== 8'h24) begin n_err++; $display("FAIL prio_status got=%h want=24", bus.irq_status); end
    tick(1);
    n_cmp++; if (bus.int_pending !== 1'b1) begin n_err++; $display("FAIL prio_req got=%b want=1", bus.int_pending); end
    pulse_ack();
    n_cmp++; if (bus.int_vector !== 8'hA4) begin n_err++; $display("FAIL prio_vec1 got=%h want=A4", bus.int_vector); end
    n_cmp++; if (bus.irq_status !== 8'h20) begin n_err++; $display("FAIL prio_status1 got=%h want=20", bus.irq_status); end
    tick(1);
    n_cmp++; if (bus.int_pending !== 1'b0) begin n_err++; $display("FAIL prio_gap got=%b want=0", bus.int_pending); end
    tick(1);
    n_cmp++; if (bus.int_pending !== 1'b1) begin n_err++; $display("FAIL prio_req2 got=%b want=1", bus.int_pending); end
    pulse_ack();
    n_cmp++; if (bus.int_vector !== 8'hAA) begin n_err++; $display("FAIL prio_vec2 got=%h want=AA", bus.int_vector); end
    n_cmp++; if (bus.irq_status !== 8'h00) begin n_err++; $display("FAIL prio_status2 got=%h want=00", bus.irq_status); end
    $display("priority: vector=%h status=%h", bus.int_vector, bus.irq_status);
  endtask

  task automatic test_masked();
    bus.irq_in = 8'h00;
    tick(3);
    write_masks(8'h00);
    bus.irq_in = 8'h02;
    tick(PEND_EDGE + 2);
    n_cmp++; if (bus.irq_status !== 8'h02) begin n_err++; $display("FAIL masked_status got=%h want=02", bus.irq_status); end
    n_cmp++; if (bus.int_pending !== 1'b0) begin n_err++; $display("FAIL masked_req got=%b want=0", bus.int_pending); end
    write_masks(8'h02);
    n_cmp++; if (bus.int_pending !== 1'b0) begin n_err++; $display("FAIL unmask_edge1 got=%b want=0", bus.int_pending); end
    tick(1);
    n_cmp++; if (bus.int_pending !== 1'b1) begin n_err++; $display("FAIL unmask_edge2 got=%b want=1", bus.int_pending); end
    pulse_ack();
    n_cmp++; if (bus.int_vector !== 8'hA2) begin n_err++; $display("FAIL masked_vector got=%h want=A2", bus.int_vector); end
    write_masks(8'hFF);
    tick(1);
    $display("masked: vector=%h masks=%h", bus.int_vector, bus.irq_masks);
  endtask

  task automatic test_clear_race();
    bus.irq_in = 8'h03;
    tick(PEND_EDGE + 1);
    n_cmp++; if (bus.irq_status !== 8'h01) begin n_err++; $display("FAIL clr_pre_status got=%h want=01", bus.irq_status); end
    n_cmp++; if (bus.int_pending !== 1'b1) begin n_err++; $display("FAIL clr_pre_req got=%b want=1", bus.int_pending); end
    bus.irq_in = 8'h43;
    tick(PEND_EDGE - 1);
    bus.ctrl_clear_all_ints = 1'b1;
    tick(1);
    bus.ctrl_clear_all_ints = 1'b0;
    n_cmp++; if (bus.irq_status !== 8'h00) begin n_err++; $display("FAIL clr_status got=%h want=00", bus.irq_status); end
    n_cmp++; if (bus.int_vector !== 8'hA2) begin n_err++; $display("FAIL clr_vector got=%h want=A2", bus.int_vector); end
    tick(1);
    n_cmp++; if (bus.int_pending !== 1'b0) begin n_err++; $display("FAIL clr_req got=%b want=0", bus.int_pending); end
    n_cmp++; if (bus.irq_status !== 8'h00) begin n_err++; $display("FAIL clr_status_hold got=%h want=00", bus.irq_status); end
    $display("clear_race: status=%h vector=%h", bus.irq_status, bus.int_vector);
  endtask

  task automatic test_back_to_back();
    bus.irq_in = 8'h53;
    tick(PEND_EDGE + 1);
    n_cmp++; if (bus.irq_status !== 8'h10) begin n_err++; $display("FAIL b2b_status got=%h want=10", bus.irq_status); end
    n_cmp++; if (bus.int_pending !== 1'b1) begin n_err++; $display("FAIL b2b_req got=%b want=1", bus.int_pending); end
    bus.irq_in = 8'h43;
    tick(PEND_EDGE);
    bus.irq_in = 8'h53;
    tick(PEND_EDGE - 1);
    pulse_ack();
    n_cmp++; if (bus.int_vector !== 8'hA8) begin n_err++; $display("FAIL b2b_vector got=%h want=A8", bus.int_vector); end
    n_cmp++; if (bus.irq_status !== 8'h10) begin n_err++; $display("FAIL b2b_kept got=%h want=10", bus.irq_status); end
    tick(1);
    n_cmp++; if (bus.int_pending !== 1'b0) begin n_err++; $display("FAIL b2b_gap got=%b want=0", bus.int_pending); end
    tick(1);
    n_cmp++; if (bus.int_pending !== 1'b1) begin n_err++; $display("FAIL b2b_rereq got=%b want=1", bus.int_pending); end
    $display("back_to_back: vector=%h status=%h", bus.int_vector, bus.irq_status);
  endtask

  task automatic test_reset_acked();
    pulse_ack();
    n_cmp++; if (bus.int_vector !== 8'hA8) begin n_err++; $display("FAIL rst_pre_vector got=%h want=A8", bus.int_vector); end
    arst = 1'b1;
    tick(1);
    arst = 1'b0;
    n_cmp++; if (bus.int_vector !== 8'h00) begin n_err++; $display("FAIL rst_acked_vector got=%h want=00", bus.int_vector); end
    n_cmp++; if (bus.int_pending !== 1'b0) begin n_err++; $display("FAIL rst_acked_req got=%b want=0", bus.int_pending); end
    n_cmp++; if (bus.irq_masks !== 8'h00) begin n_err++; $display("FAIL rst_acked_masks got=%h want=00", bus.irq_masks); end
    n_cmp++; if (bus.irq_status !== 8'h00) begin n_err++; $display("FAIL rst_acked_status got=%h want=00", bus.irq_status); end
    tick(PEND_EDGE);
    n_cmp++; if (bus.irq_status !== 8'h53) begin n_err++; $display("FAIL rst_high_lines got=%h want=53", bus.irq_status); end
    pulse_ack();
    n_cmp++; if (bus.int_vector !== 8'h00) begin n_err++; $display("FAIL idle_ack_vector got=%h want=00", bus.int_vector); end
    n_cmp++; if (bus.irq_status !== 8'h53) begin n_err++; $display("FAIL idle_ack_status got=%h want=53", bus.irq_status); end
    n_cmp++; if (bus.int_pending !== 1'b0) begin n_err++; $display("FAIL idle_ack_req got=%b want=0", bus.int_pending); end
    $display("reset_acked: status=%h vector=%h", bus.irq_status, bus.int_vector);
  endtask

  task automatic test_irq_en_drop();
    write_masks(8'hFF);
    tick(1);
    n_cmp++; if (bus.int_pending !== 1'b1) begin n_err++; $display("FAIL en_req got=%b want=1", bus.int_pending); end
    bus.irq_en = 1'b0;
    tick(1);
    n_cmp++; if (bus.int_pending !== 1'b0) begin n_err++; $display("FAIL en_drop_req got=%b want=0", bus.int_pending); end
    n_cmp++; if (bus.int_vector !== 8'h00) begin n_err++; $display("FAIL en_drop_vector got=%h want=00", bus.int_vector); end
    n_cmp++; if (bus.irq_status !== 8'h53) begin n_err++; $display("FAIL en_drop_status got=%h want=53", bus.irq_status); end
    $display("irq_en_drop: req=%b status=%h", bus.int_pending, bus.irq_status);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    arst = 1'b1;
    bus.irq_in = '0;
    bus.z_bus = '0;
    bus.ctrl_irq_masks_wrt = 1'b0;
    bus.ctrl_int_vector_wrt = 1'b0;
    bus.ctrl_int_ack = 1'b0;
    bus.ctrl_clear_all_ints = 1'b0;
    bus.irq_en = 1'b0;
    test_reset();
    test_setup();
    test_single();
    test_priority();
    test_masked();
    test_clear_race();
    test_back_to_back();
    test_reset_acked();
    test_irq_en_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
